// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: op codes, FSM state type and op-class helpers for the E-stage MDU.
// Optional build macro: MDU_MADD_EN (accumulate ops).
`default_nettype none

package e_mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_mult_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU: is_mult_op = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mult_op = 1'b1;
`endif
            default: is_mult_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/e_mdu_calc.sv
// e_mdu_calc: combinational mult/div/accumulate datapath producing {HI,LO} and a divide-by-zero flag.
// Optional build macro: MDU_MADD_EN.
`default_nettype none

module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] res_o,
    output logic        div0_o
);

    logic [63:0] prod_s, prod_u;
    logic        sdiv, neg_a, neg_b;
    logic [31:0] num, den, den_safe, quo, rem, quo_fix, rem_fix;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Signed divide runs on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
    assign sdiv     = (op_i == OP_DIV);
    assign neg_a    = sdiv && a_i[31];
    assign neg_b    = sdiv && b_i[31];
    assign num      = neg_a ? (32'd0 - a_i) : a_i;
    assign den      = neg_b ? (32'd0 - b_i) : b_i;
    assign den_safe = (den == 32'd0) ? 32'd1 : den;
    assign quo      = num / den_safe;
    assign rem      = num % den_safe;
    assign quo_fix  = (neg_a ^ neg_b) ? (32'd0 - quo) : quo;
    assign rem_fix  = neg_a ? (32'd0 - rem) : rem;

    assign div0_o = is_div_op(op_i) && (b_i == 32'd0);

    always_comb begin
        res_o = 64'd0;
        case (op_i)
            OP_MULT:         res_o = prod_s;
            OP_MULTU:        res_o = prod_u;
            OP_DIV, OP_DIVU: res_o = div0_o ? {hi_i, lo_i} : {rem_fix, quo_fix};
`ifdef MDU_MADD_EN
            OP_MADD:         res_o = {hi_i, lo_i} + prod_s;
            OP_MADDU:        res_o = {hi_i, lo_i} + prod_u;
            OP_MSUB:         res_o = {hi_i, lo_i} - prod_s;
            OP_MSUBU:        res_o = {hi_i, lo_i} - prod_u;
`endif
            default:         res_o = 64'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning HI/LO; fixed-latency ops with a busy flag for the hazard unit.
// Optional build macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU).
`default_nettype none

module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  E_mdu_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_mdu_start,
    output logic        E_mdu_busy,
    output logic [31:0] E_mdu_out
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [63:0]      pend_q, pend_d;
    logic             pend_div0_q, pend_div0_d;
    logic [63:0]      calc_res;
    logic             calc_div0;
    logic             commit, mt_ok;

    e_mdu_calc u_calc (
        .op_i   (E_mdu_op),
        .a_i    (E_A),
        .b_i    (E_B),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .res_o  (calc_res),
        .div0_o (calc_div0)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            pend_q      <= 64'd0;
            pend_div0_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pend_q      <= pend_d;
            pend_div0_q <= pend_div0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (E_mdu_start) state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        E_mdu_start = (state_q == ST_IDLE) && !Req &&
                      (is_mult_op(E_mdu_op) || is_div_op(E_mdu_op));
        E_mdu_busy  = (state_q == ST_BUSY);
        commit      = (state_q == ST_BUSY) && (cnt_q == '0);
        mt_ok       = (state_q == ST_IDLE) && !Req;
    end

    always_comb begin
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_div0_d = pend_div0_q;
        if (E_mdu_start) begin
            cnt_d       = is_div_op(E_mdu_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            pend_d      = calc_res;
            pend_div0_d = calc_div0;
        end else if (state_q == ST_BUSY && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // A divide by zero runs its full latency but leaves HI/LO untouched.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            if (!pend_div0_q) begin
                hi_d = pend_q[63:32];
                lo_d = pend_q[31:0];
            end
        end else if (mt_ok) begin
            if (E_mdu_op == OP_MTHI) hi_d = E_A;
            if (E_mdu_op == OP_MTLO) lo_d = E_A;
        end
    end

    assign E_mdu_out = (E_mdu_op == OP_MFHI) ? hi_q :
                       (E_mdu_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

`default_nettype wire
